amo_ctrl: RTL

- Multi-cycle sequencer for RV32A atomics, decoded in ID via is_amo/amoop and issued from the memory stage.
- Owns the data-memory port for the duration of an atomic: read, ALU-style modify, write-back.
- Holds the LR/SC reservation and stalls the pipeline until the atomic retires.
- Sits beside the load/store unit, muxed onto the data-memory port while busy.

---
 rtl/id_stage_pkg.sv | 26 ++
 rtl/amo_alu.sv | 39 +++
 rtl/amo_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode types for the ID stage and the atomic-memory sequencer.
package id_stage_pkg;

   typedef enum logic [3:0] {
      AMO_LR,
      AMO_SC,
      AMO_SWAP,
      AMO_ADD,
      AMO_XOR,
      AMO_AND,
      AMO_OR,
      AMO_MIN,
      AMO_MAX,
      AMO_MINU,
      AMO_MAXU
   } amoop_t;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      DONE
   } amo_state_t;

endpackage

// File: rtl/amo_alu.sv
// Combinational modify step of a read-modify-write atomic: (op, old, rs2) -> value to store.
module amo_alu
   import id_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  amoop_t                amoop,
   input  logic [DATA_WIDTH-1:0] old,
   input  logic [DATA_WIDTH-1:0] rs2,
   output logic [DATA_WIDTH-1:0] upd
);

   function automatic logic [DATA_WIDTH-1:0] smin(input logic signed [DATA_WIDTH-1:0] a,
                                                  input logic signed [DATA_WIDTH-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] smax(input logic signed [DATA_WIDTH-1:0] a,
                                                  input logic signed [DATA_WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   always_comb begin
      upd = rs2;
      case (amoop)
         AMO_LR:   upd = old;
         AMO_ADD:  upd = old + rs2;
         AMO_XOR:  upd = old ^ rs2;
         AMO_AND:  upd = old & rs2;
         AMO_OR:   upd = old | rs2;
         AMO_MIN:  upd = smin(old, rs2);
         AMO_MAX:  upd = smax(old, rs2);
         AMO_MINU: upd = (old < rs2) ? old : rs2;
         AMO_MAXU: upd = (old > rs2) ? old : rs2;
         default:  upd = rs2;
      endcase
   end

endmodule

// File: rtl/amo_ctrl.sv
// RV32A atomic sequencer: owns the data-memory port for read/modify/write and holds the LR/SC reservation.
module amo_ctrl
   import id_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  start,
   input  amoop_t                amoop,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   input  logic                  flush,
   input  logic                  st_snoop_valid,
   input  logic [ADDR_WIDTH-1:0] st_snoop_addr,
   output logic                  dm_req,
   output logic                  dm_we,
   output logic [ADDR_WIDTH-1:0] dm_addr,
   output logic [DATA_WIDTH-1:0] dm_wdata,
   input  logic                  dm_gnt,
   input  logic                  dm_rvalid,
   input  logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  stall,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  misaligned
);

   amo_state_t            state;
   amoop_t                op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] resv_addr;
   logic [DATA_WIDTH-1:0] rs2_q;
   logic [DATA_WIDTH-1:0] old_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic [DATA_WIDTH-1:0] upd;
   logic                  resv_valid;
   logic                  mis_q;
   logic                  snoop_hit;
   logic                  unused_snoop_lsb;

   amo_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .amoop(op_q),
      .old  (old_q),
      .rs2  (rs2_q),
      .upd  (upd)
   );

   // Plain stores are word-granular for reservation purposes.
   assign snoop_hit        = st_snoop_valid &&
                             (st_snoop_addr[ADDR_WIDTH-1:2] == resv_addr[ADDR_WIDTH-1:2]);
   assign unused_snoop_lsb = ^st_snoop_addr[1:0];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= IDLE;
         op_q       <= AMO_LR;
         addr_q     <= '0;
         rs2_q      <= '0;
         old_q      <= '0;
         result_q   <= '0;
         mis_q      <= 1'b0;
         resv_valid <= 1'b0;
         resv_addr  <= '0;
      end else begin
         if (flush || snoop_hit) resv_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q   <= amoop;
                  addr_q <= addr;
                  rs2_q  <= rs2_data;
                  mis_q  <= 1'b0;
                  if (addr[1:0] != 2'b00) begin
                     mis_q    <= 1'b1;
                     result_q <= '0;
                     state    <= DONE;
                  end else if (amoop == AMO_SC) begin
                     if (resv_valid && (resv_addr == addr)) begin
                        result_q <= '0;
                        state    <= WR_REQ;
                     end else begin
                        result_q <= DATA_WIDTH'(1);
                        state    <= DONE;
                     end
                  end else begin
                     state <= RD_REQ;
                  end
               end
            end
            // Flush may only abandon the atomic before the read is granted.
            RD_REQ: begin
               if (dm_gnt)     state <= RD_WAIT;
               else if (flush) state <= IDLE;
            end
            RD_WAIT: begin
               if (dm_rvalid) begin
                  old_q    <= dm_rdata;
                  result_q <= dm_rdata;
                  if (op_q == AMO_LR) begin
                     resv_valid <= 1'b1;
                     resv_addr  <= addr_q;
                     state      <= DONE;
                  end else begin
                     state <= WR_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (dm_gnt) state <= DONE;
            end
            DONE: begin
               if (op_q == AMO_SC) resv_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dm_req     = (state == RD_REQ) || (state == WR_REQ);
   assign dm_we      = (state == WR_REQ);
   assign dm_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign dm_wdata   = upd;
   assign stall      = (start && (state == IDLE)) || (state == RD_REQ) ||
                       (state == RD_WAIT) || (state == WR_REQ);
   assign done       = (state == DONE);
   assign result     = result_q;
   assign misaligned = (state == DONE) && mis_q;

endmodule
